// File: rtl/blinky_led_pio_if.sv
`default_nettype none
// ============================================================================
//  Module      : blinky_led_pio_if
//  Description : Avalon-MM slave bus bundle for the LED output PIO.
//                master modport : host/interconnect side (drives strobes)
//                slave  modport : PIO side (returns readdata)
//  Signals     : address[1:0], chipselect, write, read, writedata[31:0],
//                readdata[31:0] (registered by the slave, latency 1)
//  Revision    : 1.0  initial release
// ============================================================================
interface blinky_led_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write, read, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write, read, writedata,
      output readdata
   );
endinterface
`default_nettype wire

// File: rtl/blinky_led_pio.sv
`default_nettype none
// ============================================================================
//  Module      : blinky_led_pio
//  Description : Memory-mapped LED output PIO with hardware blink engine.
//                Registers: 0 DATA, 1 BLINK_MASK, 2 PERIOD (half-period in
//                clk cycles), 3 CTRL (read: phase, write bit0=1: restart).
//  Ports       : clk      - system clock, rising edge
//                reset    - synchronous, active-high
//                bus      - Avalon-MM slave (blinky_led_pio_if.slave)
//                out_port - registered LED drive, WIDTH bits
//  Revision    : 1.0  initial release
// ============================================================================
module blinky_led_pio #(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
   parameter logic [31:0]      DEFAULT_PERIOD = 32'd25000000
) (
   input  logic             clk,
   input  logic             reset,
   blinky_led_pio_if.slave  bus,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [1:0] C_ADDR_DATA   = 2'd0;
   localparam logic [1:0] C_ADDR_MASK   = 2'd1;
   localparam logic [1:0] C_ADDR_PERIOD = 2'd2;
   localparam logic [1:0] C_ADDR_CTRL   = 2'd3;

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] mask_q;
   logic [31:0]      period_q;
   logic [31:0]      cnt_q;
   logic             phase_q;
   logic [31:0]      readdata_q;
   logic [WIDTH-1:0] out_q;

   logic             wr_en_w;
   logic             rd_en_w;
   logic             period_wr_w;
   logic             restart_w;
   logic             wrap_w;
   logic [31:0]      rd_mux_w;

   assign wr_en_w     = bus.chipselect & bus.write;
   assign rd_en_w     = bus.chipselect & bus.read;
   assign period_wr_w = wr_en_w && (bus.address == C_ADDR_PERIOD);
   assign restart_w   = wr_en_w && (bus.address == C_ADDR_CTRL) && bus.writedata[0];
   // PERIOD==0 never wraps: the engine is frozen.
   assign wrap_w      = (period_q != 32'd0) && (cnt_q == period_q - 32'd1);

   // Read mux sees pre-edge register values, so a same-cycle write to the
   // read address returns the old contents.
   always_comb begin
      rd_mux_w = 32'd0;
      unique case (bus.address)
         C_ADDR_DATA   : rd_mux_w = 32'(data_q);
         C_ADDR_MASK   : rd_mux_w = 32'(mask_q);
         C_ADDR_PERIOD : rd_mux_w = period_q;
         C_ADDR_CTRL   : rd_mux_w = {31'd0, phase_q};
         default       : rd_mux_w = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= RESET_VALUE;
         mask_q     <= '0;
         period_q   <= DEFAULT_PERIOD;
         cnt_q      <= 32'd0;
         phase_q    <= 1'b0;
         readdata_q <= 32'd0;
         out_q      <= RESET_VALUE;
      end else begin
         // Register writes
         if (wr_en_w) begin
            case (bus.address)
               C_ADDR_DATA   : data_q   <= bus.writedata[WIDTH-1:0];
               C_ADDR_MASK   : mask_q   <= bus.writedata[WIDTH-1:0];
               C_ADDR_PERIOD : period_q <= bus.writedata;
               default       : ;
            endcase
         end

         if (rd_en_w) begin
            readdata_q <= rd_mux_w;
         end

         // Blink engine: restart beats a PERIOD write, which beats a wrap.
         if (restart_w) begin
            cnt_q   <= 32'd0;
            phase_q <= 1'b0;
         end else if (period_wr_w) begin
            cnt_q   <= 32'd0;
         end else if (period_q == 32'd0) begin
            cnt_q   <= 32'd0;
         end else if (wrap_w) begin
            cnt_q   <= 32'd0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q   <= cnt_q + 32'd1;
         end

         out_q <= data_q ^ (mask_q & {WIDTH{phase_q}});
      end
   end

   assign bus.readdata = readdata_q;
   assign out_port     = out_q;

endmodule
`default_nettype wire

// File: tb/tb_blinky_led_pio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blinky_led_pio
//  Description : Self-checking bench for blinky_led_pio (WIDTH=8,
//                RESET_VALUE=8'hA5). Reference model describes the blink
//                phase as a function of elapsed cycles since the last
//                counter anchor (reset, restart, PERIOD write).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_blinky_led_pio;

   localparam logic [7:0]  C_RV  = 8'hA5;
   localparam logic [31:0] C_DEF = 32'd25000000;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] out_port;

   blinky_led_pio_if bus ();

   blinky_led_pio #(
      .WIDTH          (8),
      .RESET_VALUE    (C_RV),
      .DEFAULT_PERIOD (C_DEF)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_err  = 0;

   // ---------------- reference model ----------------
   longint      m_cyc    = 0;   // edges elapsed
   longint      m_anchor = 0;   // edge after which the counter was 0
   logic        m_aph    = 1'b0;
   logic [7:0]  m_data   = C_RV;
   logic [7:0]  m_mask   = 8'h00;
   logic [31:0] m_per    = C_DEF;
   logic [7:0]  m_out    = C_RV;
   logic [31:0] m_rd     = 32'd0;

   // Phase after edge n: one toggle per completed PERIOD since the anchor.
   function automatic logic m_phase(input longint n);
      if (m_per == 32'd0) return m_aph;
      return m_aph ^ logic'(((n - m_anchor) / longint'(m_per)) % 2);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, advance model across the edge, check.
   task automatic step(input logic rst_in, input logic cs, input logic rd,
                       input logic wr, input logic [1:0] a, input logic [31:0] wd);
      logic ph;
      reset          = rst_in;
      bus.chipselect = cs;
      bus.read       = rd;
      bus.write      = wr;
      bus.address    = a;
      bus.writedata  = wd;
      @(posedge clk);
      ph = m_phase(m_cyc);
      if (rst_in) begin
         m_data = C_RV; m_mask = 8'h00; m_per = C_DEF;
         m_aph = 1'b0; m_anchor = m_cyc + 1;
         m_rd = 32'd0; m_out = C_RV;
      end else begin
         m_out = m_data ^ (m_mask & {8{ph}});
         if (cs && rd) begin
            case (a)
               2'd0: m_rd = {24'd0, m_data};
               2'd1: m_rd = {24'd0, m_mask};
               2'd2: m_rd = m_per;
               default: m_rd = {31'd0, ph};
            endcase
         end
         if (cs && wr) begin
            case (a)
               2'd0: m_data = wd[7:0];
               2'd1: m_mask = wd[7:0];
               2'd2: begin m_aph = ph; m_per = wd; m_anchor = m_cyc + 1; end
               default: if (wd[0]) begin m_aph = 1'b0; m_anchor = m_cyc + 1; end
            endcase
         end
      end
      m_cyc++;
      #1;
      check("out_port", {24'd0, out_port}, {24'd0, m_out});
      check("readdata", bus.readdata, m_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask
   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b0, 1'b1, a, d);
   endtask
   task automatic rd_reg(input logic [1:0] a);
      step(1'b0, 1'b1, 1'b1, 1'b0, a, 32'd0);
   endtask

   logic [31:0] exp_rst [4];

   initial begin
      reset = 1'b1;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = 2'd0; bus.writedata = 32'd0;
      #1;

      // Reset, with a strobe that must be ignored
      step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0011);
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      check("rst_out", {24'd0, out_port}, 32'h0000_00A5);
      check("rst_rdata", bus.readdata, 32'd0);
      exp_rst[0] = 32'h0000_00A5; exp_rst[1] = 32'd0;
      exp_rst[2] = 32'd25000000;  exp_rst[3] = 32'd0;
      for (int k = 0; k < 4; k++) begin
         rd_reg(2'(k));
         check("rst_read", bus.readdata, exp_rst[k]);
      end

      // Static write / readback / upper bits ignored
      wr_reg(2'd0, 32'h0000_003C);
      idle(1);
      check("static_out", {24'd0, out_port}, 32'h0000_003C);
      rd_reg(2'd0);
      check("static_rd", bus.readdata, 32'h0000_003C);
      wr_reg(2'd0, 32'hFFFF_FF00);
      rd_reg(2'd0);
      check("upper_ignored", bus.readdata, 32'd0);
      // Strobe without chipselect
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_00FF);
      rd_reg(2'd0);
      check("no_cs_write", bus.readdata, 32'd0);
      // Same-cycle read and write returns old value
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0077);
      check("rw_same", bus.readdata, 32'd0);

      // Blink: PERIOD=4, MASK=1, DATA=0; CTRL reads interleaved
      wr_reg(2'd2, 32'd4);
      wr_reg(2'd1, 32'd1);
      wr_reg(2'd0, 32'd0);
      for (int i = 0; i < 24; i++) rd_reg(2'd3);

      // Freeze with phase=1
      for (int i = 0; i < 10 && m_phase(m_cyc) != 1'b1; i++) idle(1);
      check("freeze_pre", {31'd0, m_phase(m_cyc)}, 32'd1);
      wr_reg(2'd2, 32'd0);
      idle(20);
      check("freeze_out", {24'd0, out_port}, 32'h0000_0001);
      wr_reg(2'd2, 32'd3);         // edge E
      idle(3);                     // phase toggles at E+3, visible at E+4
      check("unfreeze_hold", {24'd0, out_port}, 32'h0000_0001);
      idle(1);
      check("unfreeze_tgl", {24'd0, out_port}, 32'h0000_0000);

      // Collisions on the wrap edge
      wr_reg(2'd2, 32'd4);
      for (int i = 0; i < 8 && ((m_cyc + 1 - m_anchor) % 4) != 0; i++) idle(1);
      wr_reg(2'd2, 32'd4);
      idle(10);
      for (int i = 0; i < 8 && ((m_cyc + 1 - m_anchor) % 4) != 0; i++) idle(1);
      wr_reg(2'd3, 32'd1);
      rd_reg(2'd3);
      check("restart_ph", bus.readdata, 32'd0);
      wr_reg(2'd3, 32'd0);         // no effect
      idle(10);

      // Mid-operation reset
      wr_reg(2'd1, 32'hFF);
      wr_reg(2'd2, 32'd2);
      idle(7);
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      check("mid_rst_out", {24'd0, out_port}, 32'h0000_00A5);
      rd_reg(2'd1);
      check("mid_rst_mask", bus.readdata, 32'd0);
      rd_reg(2'd2);
      check("mid_rst_per", bus.readdata, 32'd25000000);
      rd_reg(2'd3);
      check("mid_rst_ph", bus.readdata, 32'd0);

      // Randomized traffic; short periods so blinking is exercised
      for (int i = 0; i < 1500; i++) begin
         logic [1:0]  a;
         logic [31:0] wd;
         a  = 2'($urandom_range(0, 3));
         wd = $urandom;
         if (a == 2'd2) wd = 32'($urandom_range(0, 6));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), ($urandom_range(0, 4) == 0), a, wd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/blinky_led_pio.md
Name: blinky_led_pio

Overview:
Avalon-MM memory-mapped output PIO driving the board LEDs: the write-direction counterpart to the input PIOs on the same interconnect. Software writes a static LED pattern. A per-bit blink mask plus an internal period counter let hardware toggle selected LEDs without CPU involvement. Sits on the Nios/Qsys data master's slave port and drives the top-level LED pins.

Parameters:
WIDTH, 8, number of LED outputs (1..32)
RESET_VALUE, 0, DATA register and out_port value at reset (WIDTH bits)
DEFAULT_PERIOD, 25000000, PERIOD register reset value (half-period in clk cycles; 0.5 s at 50 MHz)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
address  input  2  register word address
chipselect  input  1  slave select; qualifies read and write
write  input  1  write strobe, active-high, valid only with chipselect
read  input  1  read strobe, active-high, valid only with chipselect
writedata  input  32  write data
readdata  output  32  registered read data, read latency 1
out_port  output  WIDTH  registered LED drive

Behaviour:
- Interface: one clock; reset is synchronous and active-high. No waitrequest; every access completes in one cycle.
- Register map:
  - 0 DATA: rw, WIDTH bits.
  - 1 BLINK_MASK: rw, WIDTH bits.
  - 2 PERIOD: rw, 32 bits.
  - 3 CTRL: read {31'b0, phase}. Write with writedata[0]=1 is a restart; writedata[0]=0 has no effect.
- Writes: chipselect&write at edge E updates the addressed register at E. writedata bits above WIDTH are ignored; they read back as 0.
- Reads: chipselect&read at edge E loads readdata at E with the zero-extended register value, so data is valid the cycle after the strobe. readdata holds its value when there is no read.
- Read and write to the same address in the same cycle: readdata returns the pre-write value.
- Blink engine:
  - 32-bit counter cnt and 1-bit phase.
  - If PERIOD==0: cnt holds at 0 and phase holds.
  - Otherwise cnt increments each cycle. When cnt==PERIOD-1, cnt wraps to 0 and phase toggles. The result is a full blink cycle of 2*PERIOD clocks.
- Writing PERIOD forces cnt=0 and does not toggle phase. This takes priority over a coincident wrap.
- Restart (CTRL write with bit0=1) forces cnt=0 and phase=0. This takes priority over a wrap or a coincident PERIOD write.
- Writing PERIOD smaller than the current cnt cannot overrun, because the write also clears cnt.
- Output: out_port <= DATA ^ (BLINK_MASK & {WIDTH{phase}}), registered every cycle. A DATA write at edge E appears on out_port at E+1. A phase toggle at edge E appears at E+1.
- Reset values:
  - DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=DEFAULT_PERIOD.
  - cnt=0, phase=0.
  - readdata=0, out_port=RESET_VALUE.
- Reset asserted mid-count returns all of the above to reset values at the next edge. Accesses during reset are ignored.
- Strobes without chipselect are ignored.

Test Plan:
- Reset: assert reset 2 cycles with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0; reads of addresses 0..3 return 0xA5, 0, 25000000, 0.
- Static write: write DATA=0x3C at edge E -> out_port=0x3C at E+1. Read address 0 -> readdata=0x0000003C one cycle after the strobe. Write 0xFFFFFF00 -> readback 0x00000000.
- Blink: PERIOD=4, MASK=0x01, DATA=0x00 -> out_port[0] toggles every 4 clocks (period 8). CTRL reads alternate 0/1 in step with the toggles. Bits [7:1] stay 0.
- PERIOD=0 freeze: while phase=1, write PERIOD=0 -> phase and out_port hold indefinitely. Write PERIOD=3 -> first toggle exactly 3 cycles after the write edge.
- Collisions: PERIOD=4; on the wrap cycle write PERIOD=4 -> no toggle, next toggle 4 cycles later. On the wrap cycle write CTRL=1 -> phase=0, no toggle.
- Mid-operation reset: MASK=0xFF, PERIOD=2 blinking; assert reset 1 cycle -> out_port=RESET_VALUE, MASK=0, PERIOD=DEFAULT_PERIOD, phase=0.
